// File: rtl/mat_cmd_rx_pkg.sv
// mat_cmd_pkg: opcode/response constants, FSM states and dimension check for the command front end.
package mat_cmd_pkg;
  localparam logic [7:0] OP_MATRIX_MULT = 8'h4D;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  typedef enum logic [2:0] {IDLE, DIMS, CHECK, TX, LOAD_A, LOAD_B, START, WAIT_CALC} st_e;
  function automatic logic dims_legal(input logic [7:0] ah, aw, bh, bw, max);
    return ah != 8'd0 && ah <= max && aw != 8'd0 && aw <= max &&
           bh != 8'd0 && bh <= max && bw != 8'd0 && bw <= max && aw == bh;
  endfunction
endpackage

// File: rtl/mat_cmd_rx_if.sv
// mat_cmd_rx_if: UART, operand-buffer and engine handshake bundle of the command front end.
interface mat_cmd_rx_if #(parameter int ADDR_W = 6);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [7:0]        a_height;
  logic [7:0]        a_width;
  logic [7:0]        b_height;
  logic [7:0]        b_width;
  logic              start;
  logic              calc_done;
  logic              busy;
  logic              err;
  modport master (
    input  rx_valid, rx_data, tx_done, calc_done,
    output tx_send, tx_data, wr_en, wr_sel, wr_addr, wr_data,
           a_height, a_width, b_height, b_width, start, busy, err
  );
  modport slave (
    output rx_valid, rx_data, tx_done, calc_done,
    input  tx_send, tx_data, wr_en, wr_sel, wr_addr, wr_data,
           a_height, a_width, b_height, b_width, start, busy, err
  );
endinterface

// File: rtl/mat_cmd_rx_asm.sv
// fp_byte_assembler: packs four MSB-first bytes into a 32-bit word, flagging it the cycle after the 4th byte.
module fp_byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [31:0] r_sh;
  logic [1:0]  r_cnt;
  logic        r_wv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_wv  <= 1'b0;
    end else if (i_clear) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_wv  <= 1'b0;
    end else begin
      r_wv <= i_valid && r_cnt == 2'd3;
      if (i_valid) begin
        r_sh  <= {r_sh[23:0], i_byte};
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end
  assign o_word_valid = r_wv;
  assign o_word       = r_sh;
endmodule

// File: rtl/mat_cmd_rx.sv
// mat_cmd_rx: decodes the MATRIX_MULT command, answers ACK/NAK, loads A/B operand words and starts the engine.
module mat_cmd_rx
  import mat_cmd_pkg::*;
#(
  parameter int MAX_DIM     = 8,
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic         clk,
  input logic         rst_n,
  mat_cmd_rx_if.master bus
);
  st_e               r_state, w_next;
  logic [1:0]        r_didx;
  logic [ADDR_W-1:0] r_elem;
  logic [7:0]        r_ah, r_aw, r_bh, r_bw, r_txd;
  logic              r_txs, r_err, r_ok, r_done_q;
  logic [31:0]       r_tmo;
  logic              w_rx, w_op, w_dw, w_load, w_timed, w_tmo, w_rise, w_wr, w_last, w_legal;
  logic              w_word_valid;
  logic [31:0]       w_word;
  assign w_rx    = bus.rx_valid;
  assign w_op    = w_rx && bus.rx_data == OP_MATRIX_MULT;
  assign w_dw    = r_state == DIMS && w_rx;
  assign w_load  = r_state == LOAD_A || r_state == LOAD_B;
  assign w_timed = r_state == DIMS || w_load;
  // a byte in the same cycle as expiry wins, hence the !w_rx term
  assign w_tmo   = w_timed && !w_rx && r_tmo == 32'(TIMEOUT_CYC - 1);
  assign w_rise  = bus.tx_done && !r_done_q;
  assign w_wr    = w_word_valid && w_load;
  assign w_last  = 8'(r_elem) + 8'd1 == (r_state == LOAD_A ? r_ah * r_aw : r_bh * r_bw);
  assign w_legal = dims_legal(r_ah, r_aw, r_bh, r_bw, 8'(MAX_DIM));
  fp_byte_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (!w_load),
    .i_valid     (w_rx && w_load),
    .i_byte      (bus.rx_data),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_op ? DIMS : IDLE;
      DIMS:      w_next = w_tmo ? IDLE : (w_dw && r_didx == 2'd3) ? CHECK : DIMS;
      CHECK:     w_next = TX;
      TX:        w_next = !w_rise ? TX : r_ok ? LOAD_A : IDLE;
      LOAD_A:    w_next = w_tmo ? IDLE : (w_wr && w_last) ? LOAD_B : LOAD_A;
      LOAD_B:    w_next = w_tmo ? IDLE : (w_wr && w_last) ? START : LOAD_B;
      START:     w_next = WAIT_CALC;
      WAIT_CALC: w_next = bus.calc_done ? IDLE : WAIT_CALC;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_didx   <= '0;
      r_elem   <= '0;
      r_ah     <= '0;
      r_aw     <= '0;
      r_bh     <= '0;
      r_bw     <= '0;
      r_txd    <= '0;
      r_txs    <= 1'b0;
      r_err    <= 1'b0;
      r_ok     <= 1'b0;
      r_done_q <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_done_q <= bus.tx_done;
      r_txs    <= r_state == CHECK;
      r_tmo    <= (w_timed && !w_rx && !w_tmo) ? r_tmo + 32'd1 : 32'd0;
      if (r_state == IDLE && w_op) begin
        r_err  <= 1'b0;
        r_didx <= '0;
        r_elem <= '0;
      end
      if (w_dw) r_didx <= r_didx + 2'd1;
      if (w_dw && r_didx == 2'd0) r_ah <= bus.rx_data;
      if (w_dw && r_didx == 2'd1) r_aw <= bus.rx_data;
      if (w_dw && r_didx == 2'd2) r_bh <= bus.rx_data;
      if (w_dw && r_didx == 2'd3) r_bw <= bus.rx_data;
      if (r_state == CHECK) begin
        r_ok  <= w_legal;
        r_txd <= w_legal ? ACK : NAK;
        if (!w_legal) r_err <= 1'b1;
      end
      if (w_wr) r_elem <= (r_state == LOAD_A && w_last) ? '0 : r_elem + ADDR_W'(1);
      if (w_tmo) r_err <= 1'b1;
    end
  end
  always_comb begin
    bus.tx_send  = r_txs;
    bus.tx_data  = r_txd;
    bus.wr_en    = w_wr;
    bus.wr_sel   = r_state == LOAD_B;
    bus.wr_addr  = r_elem;
    bus.wr_data  = w_word;
    bus.a_height = r_ah;
    bus.a_width  = r_aw;
    bus.b_height = r_bh;
    bus.b_width  = r_bw;
    bus.start    = r_state == START;
    bus.busy     = r_state != IDLE;
    bus.err      = r_err;
  end
endmodule

// File: doc/mat_cmd_rx.md
Name: mat_cmd_rx

Overview:
- UART-side command front end of the matrix-multiply test design.
- Consumes one-cycle byte strobes from the UART receiver (after its posedge detector).
- Decodes the MATRIX_MULT command and its four dimension bytes, returns ACK/NAK through the UART transmitter, and assembles big-endian 4-byte IEEE-754 singles.
- Writes the assembled words into the A and B operand buffers, then pulses start to the multiply engine.

Parameters:
- MAX_DIM, 8, largest legal matrix height/width (1..MAX_DIM).
- ADDR_W, 6, element address width; must satisfy 2**ADDR_W >= MAX_DIM*MAX_DIM.
- TIMEOUT_CYC, 1000000, idle clk cycles allowed between bytes once a command has started.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- tx_send  out  1  one-cycle request to the UART transmitter.
- tx_data  out  8  byte to transmit; held stable until tx_done.
- tx_done  in  1  transmitter finished the current byte (level or pulse; the block detects it as a rising edge).
- wr_en  out  1  one-cycle operand-buffer write strobe.
- wr_sel  out  1  0 = A buffer, 1 = B buffer.
- wr_addr  out  ADDR_W  row-major element index.
- wr_data  out  32  assembled float.
- a_height, a_width, b_height, b_width  out  8 each  latched dimensions.
- start  out  1  one-cycle pulse: both operands loaded.
- calc_done  in  1  one-cycle pulse from the engine: result consumed.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky; set on NAK or timeout; cleared by the next valid opcode.

Behaviour:
- Reset values: every output is 0. FSM goes to IDLE. Counters, dimension registers and the byte shift register are cleared. Reset applies immediately, including mid-command.
- Package constants:
  - OP_MATRIX_MULT = 8'h4D; any other byte in IDLE is ignored.
  - ACK = 8'h06.
  - NAK = 8'h15.
- IDLE:
  - rx_valid with OP_MATRIX_MULT -> DIMS; clear err, byte index, element counter.
  - rx_valid with any other byte: stay in IDLE.
- DIMS:
  - The next 4 strobes latch a_height, a_width, b_height, b_width, in that order.
  - The 4th strobe -> CHECK.
- CHECK (1 cycle): legal iff all four dimensions are in 1..MAX_DIM and a_width == b_height.
  - Legal -> TX with tx_data = ACK, then LOAD_A.
  - Illegal -> TX with tx_data = NAK, set err, then IDLE.
- TX:
  - tx_send is high for exactly one cycle on state entry.
  - The FSM waits for the tx_done rising edge, then moves on.
  - rx_valid arriving in TX is dropped.
- LOAD_A and LOAD_B:
  - Bytes shift in MSB first: byte 0 -> [31:24], byte 3 -> [7:0].
  - On the cycle after the 4th byte's strobe: wr_en = 1, wr_data = word, wr_addr = element counter, wr_sel = 0 (A) or 1 (B). The element counter then increments.
  - LOAD_A ends after a_height*a_width words; clear the counter and go to LOAD_B.
  - LOAD_B ends after b_height*b_width words; go to START.
  - Products are computed in 8-bit unsigned arithmetic; the dimension limit guarantees no overflow at MAX_DIM <= 15.
- START: start = 1 for one cycle -> WAIT_CALC.
- WAIT_CALC: rx bytes are ignored; calc_done -> IDLE.
- Timeout:
  - In DIMS, LOAD_A and LOAD_B, a counter resets on every rx_valid.
  - Reaching TIMEOUT_CYC sets err, discards the partial word, and returns to IDLE with no UART response.
  - A timeout and an rx_valid in the same cycle: the byte wins and the counter clears.
- A 1x1 x 1x1 command is legal: one word per buffer.
- Latency:
  - Last word byte strobe -> wr_en: 1 cycle.
  - Last B write -> start: 1 cycle.

Decomposition:
- Package mat_cmd_pkg:
  - Opcode, ACK and NAK constants.
  - FSM state enum: IDLE, DIMS, CHECK, TX, LOAD_A, LOAD_B, START, WAIT_CALC.
  - Dimension-legality function.
- One sub-module: fp_byte_assembler. It holds a 4-byte shift register and a 2-bit byte counter. It outputs word_valid and word, and takes a clear input used on abort.

Test Plan:
- 2x2 x 2x2 load:
  - Stimulus: send 4D, 02, 02, 02, 02.
  - Required: tx_data = 06 with a single tx_send.
  - Then send 3F800000, 40000000, 40400000, 40800000 twice.
  - Required: A writes at addr 0..3 and B writes at addr 0..3 with those words; exactly one start pulse, 1 cycle after the last B write; busy stays high until calc_done.
- Mismatch:
  - Stimulus: 4D, 02, 03, 02, 02.
  - Required: tx_data = 15, err = 1, no wr_en, next byte handled in IDLE.
- Garbage then command:
  - Stimulus: bytes 00, FF, then a legal 1x1 x 1x1 command with words 3F800000 and C0000000.
  - Required: the garbage is ignored; ACK; A[0] = 3F800000, B[0] = C0000000; start.
- Timeout:
  - Stimulus: legal 2x2 command, 2 bytes of the first float, then silence for TIMEOUT_CYC (TIMEOUT_CYC overridden to 100).
  - Required: err = 1, return to IDLE; a following full command loads A starting at addr 0 with correct byte alignment.
- Reset mid-LOAD_B:
  - Stimulus: pull rst_n low asynchronously mid-way through LOAD_B.
  - Required: all outputs are 0 the same cycle; no start; a new command succeeds.
- Rectangular 3x2 x 2x4:
  - Required: 6 A writes and 8 B writes with addr 0..5 and 0..7; dims read back 3, 2, 2, 4.
